// File: rtl/usb_line_pkg.sv
// USB line-state constants and receive FSM encoding
// shared by the differential receive front end.
package usb_line_pkg;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    EOP,
    SE0_HOLD,
    BUS_RESET
  } rx_state_t;

endpackage

// File: rtl/rx_diff_if.sv
// Line pins in, recovered bit stream and
// line events out of the receive front end.
interface rx_diff_if;

  logic       rxd_pos;
  logic       rxd_neg;
  logic       nrzi_data;
  logic       rx_data_valid;
  logic       rx_active;
  logic       eop_detect;
  logic       rx_error;
  logic       bus_reset;
  logic [1:0] line_state;

  modport master (
    input  rxd_pos,
    input  rxd_neg,
    output nrzi_data,
    output rx_data_valid,
    output rx_active,
    output eop_detect,
    output rx_error,
    output bus_reset,
    output line_state
  );

  modport slave (
    output rxd_pos,
    output rxd_neg,
    input  nrzi_data,
    input  rx_data_valid,
    input  rx_active,
    input  eop_detect,
    input  rx_error,
    input  bus_reset,
    input  line_state
  );

endinterface

// File: rtl/usb_sync.sv
// Multi-flop synchroniser for one asynchronous
// line input; resets to a chosen idle level.
module usb_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic gclk,
  input  logic reset_l,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] q;

  // shift the raw pin through the chain
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      q <= {STAGES{RST_VAL}};
    end else begin
      q <= {q[STAGES-2:0], din};
    end
  end

  assign dout = q[STAGES-1];

endmodule

// File: rtl/rx_diff.sv
// Receive differential front end: classifies the
// line, recovers NRZI bits, flags EOP/error/reset.
module rx_diff
  import usb_line_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int EOP_SE0_MAX      = 2,
  parameter int RESET_SE0_CYCLES = 16
) (
  input  logic       gclk,
  input  logic       reset_l,
  rx_diff_if.master  rx
);

  localparam int CW = $clog2(RESET_SE0_CYCLES + 1);
  localparam logic [CW-1:0] CNT_RST =
    CW'(RESET_SE0_CYCLES);
  localparam logic [CW-1:0] CNT_EOP =
    CW'(EOP_SE0_MAX);

  logic          pos_s;
  logic          neg_s;
  logic [1:0]    ls;
  rx_state_t     state;
  logic [CW-1:0] se0_cnt;
  logic [CW-1:0] cnt_inc;

  logic       nrzi_q;
  logic       valid_q;
  logic       active_q;
  logic       eop_q;
  logic       err_q;
  logic       breset_q;
  logic [1:0] ls_q;

  usb_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_pos (
    .gclk    (gclk),
    .reset_l (reset_l),
    .din     (rx.rxd_pos),
    .dout    (pos_s)
  );

  usb_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync_neg (
    .gclk    (gclk),
    .reset_l (reset_l),
    .din     (rx.rxd_neg),
    .dout    (neg_s)
  );

  assign ls = {pos_s, neg_s};

  assign cnt_inc = (se0_cnt == CNT_RST) ?
    se0_cnt : se0_cnt + 1'b1;

  // line-state FSM with registered outputs
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= IDLE;
      se0_cnt  <= '0;
      nrzi_q   <= 1'b1;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
      breset_q <= 1'b0;
      ls_q     <= J;
    end else begin
      ls_q    <= ls;
      valid_q <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      if (ls == J || ls == K) begin
        se0_cnt <= '0;
      end
      unique case (state)
        IDLE: begin
          unique case (ls)
            J: ;
            K: begin
              state    <= ACTIVE;
              active_q <= 1'b1;
              valid_q  <= 1'b1;
              nrzi_q   <= 1'b0;
            end
            SE0: begin
              state   <= SE0_HOLD;
              se0_cnt <= CW'(1);
            end
            SE1: err_q <= 1'b1;
          endcase
        end
        ACTIVE: begin
          unique case (ls)
            J, K: begin
              valid_q <= 1'b1;
              nrzi_q  <= (ls == J);
            end
            SE0: begin
              state   <= EOP;
              se0_cnt <= CW'(1);
            end
            SE1: begin
              state    <= IDLE;
              active_q <= 1'b0;
              err_q    <= 1'b1;
            end
          endcase
        end
        EOP: begin
          unique case (ls)
            SE0: begin
              se0_cnt <= cnt_inc;
              if (cnt_inc == CNT_RST) begin
                state    <= BUS_RESET;
                active_q <= 1'b0;
                breset_q <= 1'b1;
                err_q    <= 1'b1;
              end
            end
            J: begin
              state    <= IDLE;
              active_q <= 1'b0;
              if (se0_cnt <= CNT_EOP) begin
                eop_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
            K, SE1: begin
              state    <= IDLE;
              active_q <= 1'b0;
              err_q    <= 1'b1;
            end
          endcase
        end
        SE0_HOLD: begin
          unique case (ls)
            SE0: begin
              se0_cnt <= cnt_inc;
              if (cnt_inc == CNT_RST) begin
                state    <= BUS_RESET;
                breset_q <= 1'b1;
              end
            end
            J: state <= IDLE;
            K: begin
              state    <= ACTIVE;
              active_q <= 1'b1;
              valid_q  <= 1'b1;
              nrzi_q   <= 1'b0;
            end
            SE1: begin
              state <= IDLE;
              err_q <= 1'b1;
            end
          endcase
        end
        BUS_RESET: begin
          unique case (ls)
            SE0: se0_cnt <= cnt_inc;
            J: begin
              state    <= IDLE;
              breset_q <= 1'b0;
            end
            K: begin
              state    <= ACTIVE;
              breset_q <= 1'b0;
              active_q <= 1'b1;
              valid_q  <= 1'b1;
              nrzi_q   <= 1'b0;
            end
            SE1: begin
              state    <= IDLE;
              breset_q <= 1'b0;
              err_q    <= 1'b1;
            end
          endcase
        end
        default: begin
          state    <= IDLE;
          active_q <= 1'b0;
          breset_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.nrzi_data     = nrzi_q;
  assign rx.rx_data_valid = valid_q;
  assign rx.rx_active     = active_q;
  assign rx.eop_detect    = eop_q;
  assign rx.rx_error      = err_q;
  assign rx.bus_reset     = breset_q;
  assign rx.line_state    = ls_q;

endmodule

// File: tb/tb_rx_diff.sv
// Bench for rx_diff: per-cycle line vectors with
// expected outputs queued and checked 3 edges later.
module tb_rx_diff;
  import usb_line_pkg::*;

  localparam int LAT = 3;

  logic gclk    = 1'b0;
  logic reset_l = 1'b1;

  rx_diff_if bus();

  rx_diff #(
    .SYNC_STAGES      (2),
    .EOP_SE0_MAX      (2),
    .RESET_SE0_CYCLES (16)
  ) dut (
    .gclk    (gclk),
    .reset_l (reset_l),
    .rx      (bus)
  );

  always #5 gclk = ~gclk;

  typedef struct packed {
    logic       nd;
    logic       dv;
    logic       act;
    logic       eop;
    logic       err;
    logic       br;
    logic [1:0] ls;
  } out_t;

  typedef struct {
    logic [1:0] ln;
    out_t       o;
  } vec_t;

  out_t  exp_q[$];
  string tag_q[$];
  vec_t  seq[$];
  int    checks = 0;
  int    errors = 0;

  function automatic out_t mk(
    logic nd, logic dv, logic act,
    logic eop, logic err, logic br,
    logic [1:0] ln);
    out_t r;
    r = '{nd, dv, act, eop, err, br, ln};
    return r;
  endfunction

  task automatic check(out_t e, string tag);
    out_t a;
    a = {bus.nrzi_data, bus.rx_data_valid,
         bus.rx_active, bus.eop_detect,
         bus.rx_error, bus.bus_reset,
         bus.line_state};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got nd=%b dv=%b act=%b eop=%b err=%b br=%b ls=%b, expected nd=%b dv=%b act=%b eop=%b err=%b br=%b ls=%b",
        tag, a.nd, a.dv, a.act, a.eop, a.err,
        a.br, a.ls, e.nd, e.dv, e.act, e.eop,
        e.err, e.br, e.ls);
    end
  endtask

  task automatic step(logic [1:0] ln, out_t e,
                      string tag);
    @(posedge gclk);
    #1;
    if (exp_q.size() == LAT) begin
      check(exp_q.pop_front(), tag_q.pop_front());
    end
    {bus.rxd_pos, bus.rxd_neg} = ln;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic add(logic [1:0] ln,
    logic nd, logic dv, logic act,
    logic eop, logic err, logic br);
    vec_t v;
    v.ln = ln;
    v.o  = mk(nd, dv, act, eop, err, br, ln);
    seq.push_back(v);
  endtask

  task automatic run(string name);
    foreach (seq[i]) begin
      step(seq[i].ln, seq[i].o,
           $sformatf("%s[%0d]", name, i));
    end
    seq.delete();
  endtask

  task automatic apply_reset(int n);
    reset_l = 1'b0;
    {bus.rxd_pos, bus.rxd_neg} = J;
    #1;
    check(mk(1, 0, 0, 0, 0, 0, J), "reset");
    exp_q.delete();
    tag_q.delete();
    repeat (n) @(posedge gclk);
    #1;
    reset_l = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, J));
      tag_q.push_back($sformatf("post_reset%0d", i));
    end
  endtask

  initial begin
    {bus.rxd_pos, bus.rxd_neg} = J;
    #2;
    apply_reset(3);

    for (int i = 0; i < 10; i++) add(J, 1,0,0,0,0,0);
    run("idle");

    add(K,   0,1,1,0,0,0);
    add(J,   1,1,1,0,0,0);
    add(K,   0,1,1,0,0,0);
    add(K,   0,1,1,0,0,0);
    add(J,   1,1,1,0,0,0);
    add(J,   1,1,1,0,0,0);
    add(K,   0,1,1,0,0,0);
    add(J,   1,1,1,0,0,0);
    add(SE0, 1,0,1,0,0,0);
    add(J,   1,0,0,1,0,0);
    add(J,   1,0,0,0,0,0);
    add(J,   1,0,0,0,0,0);
    run("pkt");

    add(K,   0,1,1,0,0,0);
    add(J,   1,1,1,0,0,0);
    add(SE0, 1,0,1,0,0,0);
    add(SE0, 1,0,1,0,0,0);
    add(SE0, 1,0,1,0,0,0);
    add(J,   1,0,0,0,1,0);
    add(J,   1,0,0,0,0,0);
    add(K,   0,1,1,0,0,0);
    add(SE0, 0,0,1,0,0,0);
    add(SE0, 0,0,1,0,0,0);
    add(J,   0,0,0,1,0,0);
    add(J,   0,0,0,0,0,0);
    run("eop_len");

    for (int i = 0; i < 20; i++) begin
      add(SE0, 0,0,0,0,0, logic'(i >= 15));
    end
    add(J,   0,0,0,0,0,0);
    add(J,   0,0,0,0,0,0);
    run("bus_rst");

    add(K,   0,1,1,0,0,0);
    for (int i = 0; i < 18; i++) begin
      add(SE0, 0,0, logic'(i < 15), 0,
          logic'(i == 15), logic'(i >= 15));
    end
    add(J,   0,0,0,0,0,0);
    add(J,   0,0,0,0,0,0);
    run("eop_abort");

    add(SE1, 0,0,0,0,1,0);
    add(J,   0,0,0,0,0,0);
    add(K,   0,1,1,0,0,0);
    add(J,   1,1,1,0,0,0);
    add(SE1, 1,0,0,0,1,0);
    add(J,   1,0,0,0,0,0);
    add(K,   0,1,1,0,0,0);
    add(J,   1,1,1,0,0,0);
    add(SE0, 1,0,1,0,0,0);
    add(J,   1,0,0,1,0,0);
    add(J,   1,0,0,0,0,0);
    run("se1");

    add(K,   0,1,1,0,0,0);
    add(J,   1,1,1,0,0,0);
    add(K,   0,1,1,0,0,0);
    add(K,   0,1,1,0,0,0);
    add(J,   1,1,1,0,0,0);
    run("mid_pkt");
    apply_reset(1);
    add(J,   1,0,0,0,0,0);
    add(K,   0,1,1,0,0,0);
    add(J,   1,1,1,0,0,0);
    add(SE0, 1,0,1,0,0,0);
    add(J,   1,0,0,1,0,0);
    add(J,   1,0,0,0,0,0);
    add(J,   1,0,0,0,0,0);
    add(J,   1,0,0,0,0,0);
    add(J,   1,0,0,0,0,0);
    run("after_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_diff.md
Name: rx_diff

Overview:
Receive-side differential front end: the counterpart of the transmit differential driver.
- Samples the USB line pair (rxd_pos/rxd_neg) and synchronises it into gclk.
- Classifies each sample as J, K, SE0 or SE1 and recovers the NRZI bit stream with a data-valid qualifier for the downstream NRZI decoder.
- Detects packet start, EOP, line errors and bus reset (long SE0). Bit rate is one line bit per gclk cycle.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per line input (minimum 2).
EOP_SE0_MAX, 2, maximum consecutive SE0 cycles still accepted as an EOP.
RESET_SE0_CYCLES, 16, consecutive SE0 cycles that assert bus_reset (must be > EOP_SE0_MAX).

Ports:
gclk  input  1  global clock; all logic on rising edge.
reset_l  input  1  global reset; asynchronous assert, active-low.
rxd_pos  input  1  line D+, asynchronous to gclk.
rxd_neg  input  1  line D-, asynchronous to gclk.
nrzi_data  output  1  recovered NRZI bit (J=1, K=0), qualified by rx_data_valid.
rx_data_valid  output  1  nrzi_data holds a packet bit this cycle.
rx_active  output  1  packet in progress (ACTIVE or EOP state).
eop_detect  output  1  one-cycle pulse on valid EOP completion.
rx_error  output  1  one-cycle pulse on SE1, malformed EOP, or K after SE0 in a packet.
bus_reset  output  1  level; high while SE0 persists at or beyond RESET_SE0_CYCLES.
line_state  output  2  synchronised {pos,neg}, registered.

Behaviour:
- Clock and reset: one clock, gclk; reset_l is asynchronous and active-low.
- Line encoding: J=2'b10, K=2'b01, SE0=2'b00, SE1=2'b11.
- Reset values:
  - synchroniser flops reset to J;
  - nrzi_data=1, line_state=J;
  - rx_data_valid, rx_active, eop_detect, rx_error, bus_reset all 0;
  - state=IDLE, se0_cnt=0.
- Latency: all outputs are registered. A pin change appears at the outputs SYNC_STAGES+1 gclk edges later.
- se0_cnt: width clog2(RESET_SE0_CYCLES+1), saturating at RESET_SE0_CYCLES. Cleared on any J or K sample.
- FSM, evaluated on the synchronised sample ls:
  - IDLE:
    - J: stay.
    - K: ACTIVE; emit valid bit 0.
    - SE0: SE0_HOLD, cnt=1.
    - SE1: rx_error pulse, stay.
  - ACTIVE:
    - J/K: stay; rx_data_valid=1, nrzi_data=(ls==J).
    - SE0: EOP, cnt=1, valid=0.
    - SE1: rx_error, IDLE.
  - EOP:
    - SE0: cnt++; at RESET_SE0_CYCLES go to BUS_RESET with rx_error pulse (packet aborted).
    - J: if cnt<=EOP_SE0_MAX, eop_detect pulse; else rx_error pulse. Go to IDLE either way.
    - K or SE1: rx_error, IDLE.
  - SE0_HOLD:
    - SE0: cnt++; at RESET_SE0_CYCLES go to BUS_RESET.
    - J: IDLE, no pulse.
    - K: ACTIVE, emit valid bit 0.
    - SE1: rx_error, IDLE.
  - BUS_RESET:
    - bus_reset=1.
    - J: IDLE.
    - K: ACTIVE, emit bit 0.
    - SE1: rx_error, IDLE.
    - bus_reset drops on the same edge as the exit.
- rx_data_valid is 0 in every state except ACTIVE (and the K-entry cycle into ACTIVE).
- While valid=0, nrzi_data holds its last value.
- eop_detect and rx_error are mutually exclusive and never high for more than one cycle.
- rx_active=1 in ACTIVE and EOP.
- A single-cycle SE0 followed by J (as produced by the transmit driver) is a valid EOP.
- Reset asserted mid-packet: immediate return to reset values; no eop_detect or rx_error is produced.

Decomposition:
- Shared package usb_line_pkg holds the line-state constants (J, K, SE0, SE1) and the rx_diff state encoding (IDLE, ACTIVE, EOP, SE0_HOLD, BUS_RESET).
- One sub-module, usb_sync: a SYNC_STAGES-deep, reset-to-value synchroniser, instantiated twice (pos, neg).

Test Plan:
1. Reset low for 3 cycles, then line J for 10 cycles → all outputs at reset values; nrzi_data=1, rx_data_valid=0, line_state=2'b10.
2. Drive K,J,K,K,J,J,K,J, then 1-cycle SE0, then J → rx_data_valid high for 8 cycles with nrzi_data 0,1,0,0,1,1,0,1, starting 3 cycles after the first K. eop_detect pulses exactly once, 3 cycles after the J following the SE0. rx_active falls on the same cycle.
3. Packet, then 3 cycles SE0, then J → no eop_detect; one rx_error pulse; return to IDLE.
4. From IDLE, hold SE0 for 20 cycles, then J → bus_reset rises 16 cycles after the first synchronised SE0 and stays high until the J is registered. No rx_error, no eop_detect.
5. During a packet, drive SE1 for 1 cycle → one rx_error pulse; rx_data_valid and rx_active drop; a subsequent K starts a new packet.
6. Assert reset_l low mid-packet for 1 cycle → all outputs at reset values asynchronously; no eop_detect; the next K after release starts a packet normally.
